// File: rtl/counter_param.sv
// Parametrised up/down counter with clamped load, wrap/saturate modes, registered flags and a boundary pulse.
// Optional prescaler enabled by COUNTER_PARAM_PRESCALE_EN (step every PRESCALE enabled cycles).
module counter_param #(
    parameter int                 WIDTH    = 8,
    parameter logic [WIDTH-1:0]   MAX_VAL  = '1,
    parameter int                 PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             at_max_q, at_max_d;
    logic             at_zero_q, at_zero_d;
    logic             wrap_q, wrap_d;
    logic             step;

`ifdef COUNTER_PARAM_PRESCALE_EN
    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;

    // Prescaler only advances on enabled cycles; load discards partial progress.
    always_comb begin
        step = en && (ps_q == PS_LAST);
        ps_d = ps_q;
        if (load) begin
            ps_d = '0;
        end else if (en) begin
            ps_d = step ? '0 : ps_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    always_comb begin
        step = en;
    end
`endif

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (step) begin
            if (up_dn) begin
                if (count_q == MAX_VAL) begin
                    wrap_d = 1'b1;
                    if (!sat_mode) begin
                        count_d = '0;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    wrap_d = 1'b1;
                    if (!sat_mode) begin
                        count_d = MAX_VAL;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
        // Flags follow the next count so they stay aligned with it.
        at_max_d  = (count_d == MAX_VAL);
        at_zero_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q   <= '0;
            at_max_q  <= 1'b0;
            at_zero_q <= 1'b1;
            wrap_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            at_max_q  <= at_max_d;
            at_zero_q <= at_zero_d;
            wrap_q    <= wrap_d;
        end
    end

    assign count   = count_q;
    assign at_max  = at_max_q;
    assign at_zero = at_zero_q;
    assign wrap    = wrap_q;

endmodule

// File: doc/counter_param.md
Name: counter_param

Overview:
- Parametrised successor to the free-running 8-bit counter.
- Adds a configurable width and terminal value, up/down direction, enable, synchronous load, and wrap or saturate mode.
- Adds registered boundary flags and a one-cycle wrap/overflow pulse.
- Used as the generic count/timer primitive in synthesis practice designs; same clk/rstn/count naming so existing counter benches carry over.

Parameters:
- WIDTH, 8: bit width of count and load_val; legal 2..32.
- MAX_VAL, 2**WIDTH-1: terminal (highest) count value; legal 1..2**WIDTH-1.
- PRESCALE, 1: enabled cycles per count step; legal 1..65535. Used only with COUNTER_PARAM_PRESCALE_EN.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rstn, input, 1: synchronous active-low reset, sampled on rising clk.
- en, input, 1: count enable; a step is taken only when en=1.
- up_dn, input, 1: direction; 1 = increment, 0 = decrement.
- load, input, 1: synchronous load strobe.
- load_val, input, WIDTH: value loaded when load=1.
- sat_mode, input, 1: 1 = saturate at bounds, 0 = wrap.
- count, output, WIDTH: current count, registered.
- at_max, output, 1: registered; 1 when count == MAX_VAL.
- at_zero, output, 1: registered; 1 when count == 0.
- wrap, output, 1: registered one-cycle pulse for a boundary event.

Behaviour:
- Reset: rstn=0 at a rising clk gives count=0, at_max=0, at_zero=1, wrap=0, prescaler=0. Reset has no effect between edges.
- Priority per edge: rstn=0, then load, then en step, then hold.
- Load: count <= min(load_val, MAX_VAL), i.e. clamped. Prescaler clears; wrap <= 0. en is ignored that cycle.
- Step, up_dn=1:
  - count < MAX_VAL: count+1.
  - count == MAX_VAL: 0 if sat_mode=0, else hold MAX_VAL.
- Step, up_dn=0:
  - count > 0: count-1.
  - count == 0: MAX_VAL if sat_mode=0, else hold 0.
- wrap: asserted in the cycle after any step taken at the bound in the step direction, in either mode (wrap or saturate attempt). Otherwise 0. Never held high for two cycles unless consecutive boundary steps occur.
- Flags: at_max and at_zero are registered with count and are always consistent with the count value in the same cycle.
- Latency: one clock from inputs to count/flags/wrap. No combinational path from inputs to outputs.
- Mode and direction: sat_mode and up_dn may change on any cycle and take effect on the next step.
- MAX_VAL < 2**WIDTH-1: values above MAX_VAL are unreachable.
- Reset mid-operation: any in-flight prescale progress is discarded.

Optional Feature:
- Macro: COUNTER_PARAM_PRESCALE_EN.
- When defined:
  - An internal prescaler (ceil(log2(PRESCALE)) bits, min 1) counts enabled cycles.
  - A step occurs only on the enabled cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - en=0 freezes the prescaler.
  - Load or reset clears it.
  - PRESCALE=1 is identical to the undefined case.
- When undefined: no prescaler logic is synthesised; every en=1 cycle is a step; PRESCALE is ignored.

Test Plan:
- Reset and count up: rstn=0 for 5 clocks, then en=1, up_dn=1, sat_mode=0, defaults. Count reads 0,1,...,255, then 0. wrap=1 exactly in the cycle count shows 0 after 255. at_max=1 only while count=255.
- Count down and wrap: load_val=3, load=1 for 1 cycle, then en=1, up_dn=0, sat_mode=0. Count reads 3,2,1,0,255. wrap pulses once, with count=255.
- Saturate: MAX_VAL=9, sat_mode=1, up_dn=1, en=1 from 0. Count holds at 9. wrap pulses every cycle while held at 9. Switch to up_dn=0 at 9: count 8,7,...,0, then holds at 0.
- Load clamp and priority: MAX_VAL=9, load_val=200, load=1 with en=1. Count=9 next cycle, wrap=0.
- Reset mid-operation: assert rstn=0 for 1 clock with count=100 and load=1. Count=0, at_zero=1, wrap=0 next cycle.
- Prescaler (COUNTER_PARAM_PRESCALE_EN, PRESCALE=4): en=1 steadily gives count +1 every 4 clocks. Deassert en for 3 clocks mid-period: the period extends by exactly 3 clocks. Without the macro, the same build steps every clock.
